// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// CTRL bit positions and the hex-to-segment table for the inverted panel.
package seg7_pkg;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_CTRL = 2'd1,
        REG_STAT = 2'd2,
        REG_RSVD = 2'd3
    } reg_idx_t;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLINK_LSB = 4;

    // Entry n is the segment pattern (g..a) for hex digit n; listed F down to 0.
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h4E, 7'h4F, 7'h73, 7'h0F, 7'h67, 7'h7E, 7'h7C, 7'h7F,
        7'h38, 7'h6F, 7'h6D, 7'h74, 7'h79, 7'h5B, 7'h30, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_CODES[nib];
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Digit scan engine: slot timer, digit sequencer, anti-ghost blanking and
// registered COMM/SEG drive. Optional blink gating under SEG7_BLINK_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 3840,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 8000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] disp,
    input  logic        enable,
`ifdef SEG7_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [1:0]  dd,
    output logic        frame_tick,
    output logic [3:0]  comm,
    output logic [6:0]  seg
);

    localparam int CW = $clog2(REFRESH_DIV + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt;
    logic          slot_end;
    logic          digit_blanked;
    logic          dark;
    logic [3:0]    nibble;
    logic [3:0]    comm_next;
    logic [6:0]    seg_next;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_tick = slot_end && (dd == 2'd0);

    // Digits are visited 3,2,1,0 so the frame ends on the most significant digit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt <= '0;
            dd       <= 2'd3;
        end else if (slot_end) begin
            slot_cnt <= '0;
            dd       <= dd - 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= BLINK_RELOAD;
            blink_phase <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt   <= BLINK_RELOAD;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt - BW'(1);
        end
    end

    assign digit_blanked = blink_phase && blink_mask[dd];
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 0);
    assign digit_blanked    = 1'b0;
`endif

    always_comb begin
        case (dd)
            2'd0:    nibble = disp[15:12];
            2'd1:    nibble = disp[11:8];
            2'd2:    nibble = disp[7:4];
            default: nibble = disp[3:0];
        endcase
    end

    assign dark = !enable || (slot_cnt < BLANK_END) || digit_blanked;

    always_comb begin
        comm_next = 4'b1111;
        seg_next  = '0;
        if (!dark) begin
            comm_next = ~(4'b0001 << dd);
            seg_next  = hex_to_seg(nibble);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            comm <= 4'b1111;
            seg  <= '0;
        end else begin
            comm <= comm_next;
            seg  <= seg_next;
        end
    end

endmodule

// File: rtl/seg7_iomem_display.sv
// picosoc iomem-mapped 4-digit seven-segment controller: bus registers and decode.
// Define SEG7_BLINK_EN to enable per-digit blinking through CTRL[7:4].
module seg7_iomem_display
    import seg7_pkg::*;
#(
    parameter logic [7:0] BASE_HI      = 8'h04,
    parameter int         REFRESH_DIV  = 3840,
    parameter int         BLANK_CYCLES = 16,
    parameter int         BLINK_DIV    = 8000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [3:0]  comm,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    logic        hit;
    reg_idx_t    reg_idx;
    logic [15:0] shadow;
    logic [15:0] disp;
    logic        enable;
    logic [7:0]  frame_cnt;
    logic [7:0]  ctrl_value;
    logic [31:0] rd_value;
    logic [1:0]  dd;

    assign hit     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
    assign reg_idx = reg_idx_t'(iomem_addr[3:2]);

`ifdef SEG7_BLINK_EN
    logic [3:0] blink_mask;
    assign ctrl_value = {blink_mask, 3'b000, enable};
`else
    assign ctrl_value = {7'd0, enable};
`endif

    always_comb begin
        rd_value = '0;
        case (reg_idx)
            REG_DATA: rd_value[15:0] = shadow;
            REG_CTRL: rd_value[7:0]  = ctrl_value;
            REG_STAT: rd_value       = {16'd0, frame_cnt, 6'd0, dd};
            default:  rd_value       = '0;
        endcase
    end

    // The ready term inside hit guarantees a one-cycle gap between acknowledges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            shadow      <= '0;
            enable      <= 1'b1;
`ifdef SEG7_BLINK_EN
            blink_mask  <= '0;
`endif
        end else begin
            iomem_ready <= hit;
            iomem_rdata <= hit ? rd_value : '0;
            if (hit) begin
                case (reg_idx)
                    REG_DATA: begin
                        if (iomem_wstrb[0]) shadow[7:0]  <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) shadow[15:8] <= iomem_wdata[15:8];
                    end
                    REG_CTRL: begin
                        if (iomem_wstrb[0]) begin
                            enable     <= iomem_wdata[CTRL_EN_BIT];
`ifdef SEG7_BLINK_EN
                            blink_mask <= iomem_wdata[CTRL_BLINK_LSB +: 4];
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Displayed value only changes at frame boundaries so a frame never tears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp      <= '0;
            frame_cnt <= '0;
        end else if (frame_tick) begin
            disp      <= shadow;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    logic unused_bus;
    assign unused_bus = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16], iomem_wstrb[3:2]};

    seg7_scan #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) u_scan (
        .clk        (clk),
        .resetn     (resetn),
        .disp       (disp),
        .enable     (enable),
`ifdef SEG7_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .dd         (dd),
        .frame_tick (frame_tick),
        .comm       (comm),
        .seg        (seg)
    );

endmodule

// File: tb/tb_seg7_iomem_display.sv
// Self-checking bench for seg7_iomem_display: register table plus scan/frame sequences.
module tb_seg7_iomem_display;

    localparam int RDIV  = 32;
    localparam int BLANK = 4;
    localparam int BDIV  = 300;
    localparam logic [31:0] BASE = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [3:0]  comm;
    logic [6:0]  seg;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h30, 7'h5B, 7'h79, 7'h74, 7'h6D, 7'h6F, 7'h38,
                                 7'h7F, 7'h7C, 7'h7E, 7'h67, 7'h0F, 7'h73, 7'h4F, 7'h4E};
    logic [3:0] comm_ref [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn)
        if (!resetn) edge_n <= 0;
        else         edge_n <= edge_n + 1;

    seg7_iomem_display #(
        .BASE_HI      (8'h04),
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK),
        .BLINK_DIV    (BDIV)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .comm        (comm),
        .seg         (seg),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                       output logic [31:0] rd, output logic got);
        rd  = '0;
        got = 1'b0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin
                got = 1'b1;
                rd  = iomem_rdata;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(posedge clk); #1;
        check("ready_single_cycle", {31'd0, iomem_ready}, 32'd0);
    endtask

    task automatic wait_tick();
        logic ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_tick_seen", {31'd0, ok}, 32'd1);
    endtask

    // Sample the middle of each slot of the frame following the next frame_tick.
    task automatic check_frame(input logic [15:0] val);
        logic [3:0] nib;
        int d;
        wait_tick();
        @(posedge clk);
        @(posedge clk); #1;
        check("slot_start_blank_comm", {28'd0, comm}, 32'hF);
        check("slot_start_blank_seg", {25'd0, seg}, 32'h0);
        repeat (16) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                repeat (RDIV) @(posedge clk);
                #1;
            end
            d   = 3 - s;
            nib = 4'(val >> (12 - 4 * d));
            check("frame_comm", {28'd0, comm}, {28'd0, comm_ref[d]});
            check("frame_seg", {25'd0, seg}, {25'd0, seg_ref[nib]});
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        logic        got;
        logic [7:0]  fc0;
        logic        r0, r1, r2;
        int          lit_cnt;
        int          bad, lit0_p0, lit0_p1, lit1_p1, m, d, c, ph;
        logic [3:0]  exp_c;

        vecs[0]  = '{BASE | 32'h0,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[1]  = '{BASE | 32'h4,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h1};
        vecs[2]  = '{BASE | 32'hC,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[3]  = '{BASE | 32'h0,  4'b0011, 32'h0000_1234, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{BASE | 32'h0,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0000_1234};
        vecs[5]  = '{BASE | 32'h0,  4'b1100, 32'hBEEF_5678, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{BASE | 32'h0,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0000_1234};
        vecs[7]  = '{BASE | 32'h0,  4'b0001, 32'h0000_00FF, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{BASE | 32'h0,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0000_12FF};
        vecs[9]  = '{BASE | 32'h0,  4'b0011, 32'h0000_1234, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{BASE | 32'h4,  4'b0001, 32'h0000_00F1, 1'b1, 1'b0, 32'h0};
`ifdef SEG7_BLINK_EN
        vecs[11] = '{BASE | 32'h4,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0000_00F1};
`else
        vecs[11] = '{BASE | 32'h4,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0000_0001};
`endif
        vecs[12] = '{BASE | 32'h4,  4'b0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{BASE | 32'hC,  4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{BASE | 32'hC,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[15] = '{32'h0500_0000, 4'b0000, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[16] = '{BASE | 32'h10, 4'b0000, 32'h0,         1'b1, 1'b1, 32'h0000_1234};

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        #25;
        check("reset_comm", {28'd0, comm}, 32'hF);
        check("reset_seg", {25'd0, seg}, 32'h0);
        check("reset_ready", {31'd0, iomem_ready}, 32'h0);
        check("reset_rdata", iomem_rdata, 32'h0);
        check("reset_frame_tick", {31'd0, frame_tick}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus(vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, got);
            check($sformatf("vec%0d_ready", i), {31'd0, got}, {31'd0, vecs[i].exp_ready});
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        check_frame(16'h1234);

        bus(BASE | 32'h0, 4'b0011, 32'h0000_ABCD, rd, got);
        check("midframe_hold_comm", {28'd0, comm}, 32'hE);
        check("midframe_hold_seg", {25'd0, seg}, 32'h30);
        check_frame(16'hABCD);

        bus(BASE | 32'h4, 4'b0001, 32'h0, rd, got);
        check("disable_comm_next_cycle", {28'd0, comm}, 32'hF);
        check("disable_seg_next_cycle", {25'd0, seg}, 32'h0);
        lit_cnt = 0;
        for (int i = 0; i < 4 * RDIV + 8; i++) begin
            @(posedge clk); #1;
            if (comm != 4'b1111 || seg != 7'd0) lit_cnt++;
        end
        check("disabled_lit_cycles", lit_cnt, 0);
        bus(BASE | 32'h8, 4'b0000, 32'h0, rd, got);
        fc0 = rd[15:8];
        wait_tick();
        bus(BASE | 32'h8, 4'b0000, 32'h0, rd, got);
        check("stat_frame_count_disabled", {24'd0, rd[15:8]}, {24'd0, 8'(fc0 + 8'd1)});
        check("stat_dd_after_tick", {30'd0, rd[1:0]}, 32'd3);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'h8;
        iomem_wstrb = 4'b0000;
        @(posedge clk); #1; r0 = iomem_ready;
        @(posedge clk); #1; r1 = iomem_ready;
        @(posedge clk); #1; r2 = iomem_ready;
        iomem_valid = 1'b0;
        check("held_valid_ready0", {31'd0, r0}, 32'd1);
        check("held_valid_ready1", {31'd0, r1}, 32'd0);
        check("held_valid_ready2", {31'd0, r2}, 32'd1);
        @(posedge clk); #1;
        check("held_valid_release", {31'd0, iomem_ready}, 32'd0);

        bus(BASE | 32'h4, 4'b0001, 32'h1, rd, got);

        wait_tick();
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset_lit", {28'd0, comm}, 32'h7);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'h0;
        iomem_wstrb = 4'b0000;
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_comm", {28'd0, comm}, 32'hF);
        check("async_reset_seg", {25'd0, seg}, 32'h0);
        check("async_reset_ready", {31'd0, iomem_ready}, 32'h0);
        check("async_reset_tick", {31'd0, frame_tick}, 32'h0);
        iomem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_no_ready", {31'd0, iomem_ready}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        bus(BASE | 32'h0, 4'b0000, 32'h0, rd, got);
        check("post_reset_data", rd, 32'h0);
        bus(BASE | 32'h4, 4'b0000, 32'h0, rd, got);
        check("post_reset_ctrl", rd, 32'h1);
        bus(BASE | 32'h8, 4'b0000, 32'h0, rd, got);
        check("post_reset_stat", rd, 32'h3);

`ifdef SEG7_BLINK_EN
        bus(BASE | 32'h4, 4'b0001, 32'h11, rd, got);
        bad = 0; lit0_p0 = 0; lit0_p1 = 0; lit1_p1 = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            m  = edge_n - 1;
            d  = 3 - ((m / RDIV) % 4);
            c  = m % RDIV;
            ph = (m / BDIV) % 2;
            exp_c = (c < BLANK || (ph == 1 && d == 0)) ? 4'b1111 : comm_ref[d];
            if (comm !== exp_c) bad++;
            if ((comm == 4'b1111) != (seg == 7'd0)) bad++;
            if (comm == 4'b1110) begin
                if (ph == 1) lit0_p1++;
                else         lit0_p0++;
            end
            if (comm == 4'b1101 && ph == 1) lit1_p1++;
        end
        check("blink_model_mismatches", bad, 0);
        check("blink_digit0_lit_phase1", lit0_p1, 0);
        check("blink_digit0_lit_phase0", {31'd0, lit0_p0 > 0}, 32'd1);
        check("blink_digit1_lit_phase1", {31'd0, lit1_p1 > 0}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
